isqrt_n: RTL
============

ISQRT_N -- requirements
Module: isqrt_n

Interface
REQ-001 SHALL have parameter: WIDTH, 8, radicand width in bits; even, >= 2.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: st  input  1  start request; level, held by requester until done seen.
REQ-005 SHALL have port: n  input  WIDTH  unsigned radicand, sampled only when a start is accepted.
REQ-006 SHALL have port: sqrt  output  WIDTH/2  floor(sqrt(n)) of the accepted operand.
REQ-007 SHALL have port: done  output  1  result valid; held until st deasserted.
REQ-008 SHALL have port: busy  output  1  high while in CALC.
REQ-009 SHALL have port (ISQRT_REM_EN only): rem  output  WIDTH/2+1  n - sqrt*sqrt.
REQ-010 SHALL use one clock and a synchronous, active-high reset; no other clocks or async paths.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE: on edge with st=1, SHALL latch n into internal operand, clear root/partial remainder, load iteration counter with WIDTH/2, go to CALC.
REQ-013 CALC: each edge SHALL resolve exactly one root bit, MSB first, via restoring digit-by-digit method (trial = {rem, next 2 operand bits} - {root, 2'b01}; bit=1 if trial >= 0).
REQ-014 CALC SHALL last exactly WIDTH/2 edges, then go to DONE; done rises WIDTH/2+1 edges after the edge accepting st (5 edges for WIDTH=8).
REQ-015 DONE: done=1, sqrt/rem stable; SHALL stay in DONE while st=1; on edge with st=0, SHALL go to IDLE and drop done.
REQ-016 A new start SHALL require st low for at least one edge after done; st held high across DONE->IDLE SHALL NOT retrigger.
REQ-017 Changes on n while in CALC or DONE SHALL NOT affect result.
REQ-018 st deasserting during CALC SHALL NOT abort; computation completes, DONE exits on next edge with st=0.
REQ-019 sqrt and rem SHALL hold last result in IDLE until next CALC start; internal partials SHALL NOT be visible on sqrt while busy (outputs register only on CALC->DONE).
REQ-020 Arithmetic SHALL be unsigned; partial remainder WIDTH/2+2 bits, no overflow for any n in [0, 2^WIDTH-1].
REQ-021 WIDTH odd or < 2 SHALL cause elaboration error.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, done=0, busy=0, sqrt=0, rem=0, counter=0, regardless of state (incl. mid-CALC).
REQ-023 rst SHALL take priority over st on the same edge; st high on the first edge after reset release SHALL be accepted.

Configuration
REQ-024 Macro ISQRT_REM_EN defined: rem port and final-remainder register present, rem valid with done.
REQ-025 ISQRT_REM_EN undefined: rem port absent; remainder kept internally only as needed for iteration; all other behaviour and timing identical.

Structure
REQ-026 Package isqrt_pkg SHALL hold the state enum (IDLE, CALC, DONE) and a clog2-style constant function for counter width.
REQ-027 One combinational sub-module isqrt_step (parameter WIDTH) SHALL perform one digit iteration; isqrt_n instantiates it once and iterates it sequentially.

Verification
REQ-028 WIDTH=8: n=0x00, st held to done -> sqrt=0x0, rem=0, done at edge 5.
REQ-029 WIDTH=8: n=0xFF -> sqrt=0xF, rem=30; n=0x90 -> sqrt=0xC, rem=0; n=0x0F -> sqrt=0x3, rem=6.
REQ-030 WIDTH=8: st held high 10 edges past done -> done stays 1, no restart; st low -> done 0 next edge, busy 0.
REQ-031 WIDTH=8: n=0x64 accepted, n changed to 0xFF on edge 2 -> sqrt=0xA.
REQ-032 rst pulsed on edge 3 of CALC -> next edge IDLE, outputs 0, done never asserted; restart n=0x51 -> sqrt=0x9.
REQ-033 WIDTH=16 exhaustive sweep 0..65535 -> sqrt=floor(sqrt(n)), rem=n-sqrt^2, done at edge 9 each.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the isqrt_n iterative integer square root.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold the unsigned value 'value' (at least 1).
    function automatic int cnt_bits(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) <= value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration: consumes two radicand
// bits and resolves one root bit. Purely combinational.
module isqrt_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH/2+1:0] rem_i,
    input  logic [WIDTH/2-1:0] root_i,
    input  logic [1:0]         pair_i,
    output logic [WIDTH/2+1:0] rem_o,
    output logic [WIDTH/2-1:0] root_o
);

    localparam int HALF = WIDTH / 2;
    localparam int RW   = HALF + 2;
    localparam int TW   = HALF + 4;

    logic [TW-1:0] acc;
    logic [TW-1:0] sub;
    logic [TW-1:0] diff;
    logic          ge;
    logic          unused_bits;

    always_comb begin
        acc  = {rem_i, pair_i};
        sub  = {2'b00, root_i, 2'b01};
        diff = acc - sub;
        ge   = (acc >= sub);
        // A kept remainder is bounded by 2*root, so the low RW bits always hold it.
        rem_o  = ge ? diff[RW-1:0] : acc[RW-1:0];
        root_o = (root_i << 1) | HALF'(ge);
    end

    assign unused_bits = ^{acc[TW-1:RW], diff[TW-1:RW]};

endmodule

// File: rtl/isqrt_n.sv
// Sequential floor(sqrt(n)) with st/done handshake, one root bit per clock.
// Define ISQRT_REM_EN to add the rem output (n - sqrt*sqrt).
module isqrt_n
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st,
    input  logic [WIDTH-1:0]   n,
    output logic [WIDTH/2-1:0] sqrt,
    output logic               done,
`ifdef ISQRT_REM_EN
    output logic               busy,
    output logic [WIDTH/2:0]   rem
`else
    output logic               busy
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int RW   = HALF + 2;
    localparam int CW   = cnt_bits(HALF);

    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
        $error("isqrt_n: WIDTH must be even and >= 2");
    end

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [HALF-1:0] root_q, root_d;
    logic [RW-1:0]   prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HALF-1:0] sqrt_q, sqrt_d;
    logic [RW-1:0]   step_rem;
    logic [HALF-1:0] step_root;
`ifdef ISQRT_REM_EN
    logic [HALF:0]   rem_q, rem_d;
`endif

    isqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (prem_q),
        .root_i (root_q),
        .pair_i (op_q[WIDTH-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        root_d  = root_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        sqrt_d  = sqrt_q;
`ifdef ISQRT_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (st) begin
                    op_d    = n;
                    root_d  = '0;
                    prem_d  = '0;
                    cnt_d   = CW'(HALF);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    op_d   = op_q << 2;
                    root_d = step_root;
                    prem_d = step_rem;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    // Results become visible only here, so partials never leak out.
                    sqrt_d  = root_q;
`ifdef ISQRT_REM_EN
                    rem_d   = prem_q[HALF:0];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!st) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            root_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            sqrt_q  <= '0;
`ifdef ISQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            root_q  <= root_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            sqrt_q  <= sqrt_d;
`ifdef ISQRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign sqrt = sqrt_q;
    assign done = (state_q == DONE);
    assign busy = (state_q == CALC);
`ifdef ISQRT_REM_EN
    assign rem  = rem_q;
`endif

endmodule
